// File: rtl/hazard_fwd_unit.sv
`default_nettype none
//==============================================================================
// Module   : hazard_fwd_unit
// Purpose  : Operand forwarding and load-use stall unit placed between the
//            register-file read stage and the ALU. Tracks DEPTH in-flight
//            register writes and forwards the youngest matching result.
// Options  : HAZARD_PERF_EN adds saturating stall_cycles / fwd_events counters.
// Revision : 1.0 - initial parametrised release
//==============================================================================
module hazard_fwd_unit #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic                          issue_wr,
  input  logic [REG_AW-1:0]             issue_dest,
  input  logic                          issue_load,
  input  logic [REG_AW-1:0]             src1_addr,
  input  logic [REG_AW-1:0]             src2_addr,
  input  logic                          src1_used,
  input  logic                          src2_used,
  input  logic [DATA_W-1:0]             rf_data1,
  input  logic [DATA_W-1:0]             rf_data2,
  input  logic [DEPTH*DATA_W-1:0]       stage_data,
  input  logic                          flush,
  output logic [DATA_W-1:0]             op1_value,
  output logic [DATA_W-1:0]             op2_value,
  output logic [REG_AW:0]               fwd_sel1,
  output logic [REG_AW:0]               fwd_sel2,
  output logic                          stall,
`ifdef HAZARD_PERF_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   fwd_events,
`endif
  output logic [$clog2(DEPTH+1)-1:0]    inflight_cnt
);

  localparam int SEL_W = REG_AW + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // In-flight write tracking: index 0 is the youngest (ALU output stage)
  logic [DEPTH-1:0]  v_q, v_d;
  logic [DEPTH-1:0]  load_q, load_d;
  logic [REG_AW-1:0] dest_q [DEPTH];
  logic [REG_AW-1:0] dest_d [DEPTH];

  logic unready1, unready2;

  // Youngest-match search per operand; descending loop so the lowest index wins
  always_comb begin
    fwd_sel1  = '0;
    fwd_sel2  = '0;
    op1_value = rf_data1;
    op2_value = rf_data2;
    unready1  = 1'b0;
    unready2  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v_q[i] && (dest_q[i] == src1_addr) && src1_used) begin
        fwd_sel1  = SEL_W'(i + 1);
        op1_value = stage_data[i*DATA_W +: DATA_W];
        unready1  = load_q[i] && (i < LOAD_READY);
      end
      if (v_q[i] && (dest_q[i] == src2_addr) && src2_used) begin
        fwd_sel2  = SEL_W'(i + 1);
        op2_value = stage_data[i*DATA_W +: DATA_W];
        unready2  = load_q[i] && (i < LOAD_READY);
      end
    end
  end

  // A younger unready load shadows any older ready copy, so stall rather than skip it
  always_comb begin
    stall = issue_valid && (unready1 || unready2);
  end

  // Next-state: shift every entry one stage older; bubble into stage 0 on stall/flush
  always_comb begin
    v_d    = '0;
    load_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dest_d[i] = '0;
    end
    if (!(stall || flush)) begin
      v_d[0]    = issue_valid && issue_wr;
      load_d[0] = issue_load;
      dest_d[0] = issue_dest;
    end
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]    = v_q[i-1];
      load_d[i] = load_q[i-1];
      dest_d[i] = dest_q[i-1];
    end
  end

  // Tracking state register; reset invalidates every entry immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q    <= '0;
      load_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      load_q <= load_d;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= dest_d[i];
      end
    end
  end

  // Occupancy is the popcount of the registered valid bits
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(v_q[i]);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] fwd_events_q;
  logic        fwd_hit;

  // A forwarding event needs a valid issuing instruction and any non-RF source
  always_comb begin
    fwd_hit = issue_valid && ((fwd_sel1 != '0) || (fwd_sel2 != '0));
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (fwd_hit && (fwd_events_q != '1)) begin
        fwd_events_q <= fwd_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_hazard_fwd_unit
// Purpose  : Self-checking bench for hazard_fwd_unit: directed scenarios then
//            randomized traffic against a queue-based reference model.
// Options  : HAZARD_PERF_EN also checks the performance counters.
// Revision : 1.0 - initial release
//==============================================================================
module tb_hazard_fwd_unit;

  localparam int DATA_W     = 16;
  localparam int REG_AW     = 4;
  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    issue_valid, issue_wr, issue_load, flush;
  logic [REG_AW-1:0]       issue_dest, src1_addr, src2_addr;
  logic                    src1_used, src2_used;
  logic [DATA_W-1:0]       rf_data1, rf_data2;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic [DATA_W-1:0]       op1_value, op2_value;
  logic [REG_AW:0]         fwd_sel1, fwd_sel2;
  logic                    stall;
  logic [1:0]              inflight_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0]             stall_cycles, fwd_events;
  int unsigned             exp_stall_cycles, exp_fwd_events;
`endif

  hazard_fwd_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
    .issue_load(issue_load),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .src1_used(src1_used), .src2_used(src2_used),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .stage_data(stage_data), .flush(flush),
    .op1_value(op1_value), .op2_value(op2_value),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall(stall),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .fwd_events(fwd_events),
`endif
    .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: history of issued slots, youngest at the front
  typedef struct packed {
    bit       v;
    bit [3:0] dest;
    bit       ld;
  } ent_t;
  ent_t mq[$];

  // Values observed at the most recent step, for directed spot checks
  logic [15:0] obs_op1, obs_op2;
  logic [4:0]  obs_sel1, obs_sel2;
  logic        obs_stall;
  logic [1:0]  obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
`ifdef HAZARD_PERF_EN
    exp_stall_cycles = 0;
    exp_fwd_events   = 0;
`endif
  endtask

  // Youngest in-flight write to a used register supplies the operand
  task automatic lookup(input bit [3:0] a, input bit u, input logic [15:0] rf,
                        output logic [4:0] sel, output logic [15:0] val, output bit unready);
    sel = 0; val = rf; unready = 0;
    if (u) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].v && mq[i].dest == a) begin
          sel     = 5'(i + 1);
          val     = stage_data[i*DATA_W +: DATA_W];
          unready = mq[i].ld && (i < LOAD_READY);
          break;
        end
      end
    end
  endtask

  // One cycle: drive at negedge, check mid-cycle, then let the edge update both sides
  task automatic step(input bit v, input bit wr, input bit [3:0] dst, input bit ld,
                      input bit [3:0] a1, input bit u1, input bit [3:0] a2, input bit u2,
                      input bit fl);
    logic [4:0]  es1, es2;
    logic [15:0] ev1, ev2;
    bit          ur1, ur2, est;
    int          ecnt;
    issue_valid = v; issue_wr = wr; issue_dest = dst; issue_load = ld;
    src1_addr = a1; src1_used = u1; src2_addr = a2; src2_used = u2; flush = fl;
    #2;
    lookup(a1, u1, rf_data1, es1, ev1, ur1);
    lookup(a2, u2, rf_data2, es2, ev2, ur2);
    est  = v && (ur1 || ur2);
    ecnt = 0;
    foreach (mq[i]) ecnt += int'(mq[i].v);
    obs_op1 = op1_value; obs_op2 = op2_value; obs_sel1 = fwd_sel1; obs_sel2 = fwd_sel2;
    obs_stall = stall; obs_cnt = inflight_cnt;
    chk("fwd_sel1", 32'(fwd_sel1), 32'(es1));
    chk("fwd_sel2", 32'(fwd_sel2), 32'(es2));
    chk("op1_value", 32'(op1_value), 32'(ev1));
    chk("op2_value", 32'(op2_value), 32'(ev2));
    chk("stall", 32'(stall), 32'(est));
    chk("inflight_cnt", 32'(inflight_cnt), 32'(ecnt));
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, exp_stall_cycles);
    chk("fwd_events", fwd_events, exp_fwd_events);
`endif
    @(posedge clk);
    if (est || fl) mq.push_front('0);
    else mq.push_front('{v: (v && wr), dest: dst, ld: ld});
    void'(mq.pop_back());
`ifdef HAZARD_PERF_EN
    if (est) exp_stall_cycles++;
    if (v && (es1 != 0 || es2 != 0)) exp_fwd_events++;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1; issue_wr = 1; issue_dest = 1; issue_load = 1; flush = 0;
    src1_addr = 1; src2_addr = 1; src1_used = 1; src2_used = 1;
    rf_data1 = 16'h1234; rf_data2 = 16'h5678; stage_data = 48'hAAAA_BBBB_CCCC;
    model_clear();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cnt", 32'(inflight_cnt), 0);
    chk("rst_sel1", 32'(fwd_sel1), 0);
    chk("rst_op1", 32'(op1_value), 32'h1234);
    chk("rst_op2", 32'(op2_value), 32'h5678);
    @(negedge clk);
    reset = 1'b0;

    // ADD R1 then read R1 from stage 0
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    stage_data = {16'h0, 16'h0, 16'h00A5};
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    chk("tp1_sel1", 32'(obs_sel1), 1);
    chk("tp1_op1", 32'(obs_op1), 32'h00A5);
    chk("tp1_stall", 32'(obs_stall), 0);

    // Two writes to R2; youngest wins
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0);
    stage_data = {16'h0, 16'h1111, 16'h2222};
    step(1, 0, 0, 0, 2, 1, 2, 1, 0);
    chk("tp2_sel1", 32'(obs_sel1), 1);
    chk("tp2_op2", 32'(obs_op2), 32'h2222);

    // LDR R3 then immediate use: one stall, then forward from stage 1
    idle(); idle(); idle();
    step(1, 1, 3, 1, 0, 0, 0, 0, 0);
    stage_data = {16'h0, 16'h0, 16'hDEAD};
    step(1, 1, 8, 0, 3, 1, 0, 0, 0);
    chk("tp3_stall", 32'(obs_stall), 1);
    stage_data = {16'h0, 16'hBEEF, 16'h0};
    step(1, 1, 8, 0, 3, 1, 0, 0, 0);
    chk("tp3_stall_drop", 32'(obs_stall), 0);
    chk("tp3_sel1", 32'(obs_sel1), 2);
    chk("tp3_op1", 32'(obs_op1), 32'hBEEF);

    // Flushed write to R4 is never tracked
    idle(); idle(); idle();
    step(1, 1, 4, 0, 0, 0, 0, 0, 1);
    chk("tp4_cnt_now", 32'(obs_cnt), 0);
    idle();
    step(1, 0, 0, 0, 4, 1, 4, 1, 0);
    chk("tp4_sel1", 32'(obs_sel1), 0);
    chk("tp4_op1", 32'(obs_op1), 32'(rf_data1));

    // Flush with a stalling use: flush wins, nothing remembered
    step(1, 1, 9, 1, 0, 0, 0, 0, 0);
    step(1, 1, 10, 0, 9, 1, 0, 0, 1);
    chk("tp_flush_stall", 32'(obs_stall), 1);
    step(1, 0, 0, 0, 10, 1, 0, 0, 0);
    chk("tp_flush_kill", 32'(obs_sel1), 0);

    // Fill and drain
    idle(); idle(); idle();
    step(1, 1, 5, 0, 0, 0, 0, 0, 0);
    step(1, 1, 6, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0);
    idle(); chk("tp5_cnt_full", 32'(obs_cnt), 3);
    idle(); chk("tp5_cnt_2", 32'(obs_cnt), 2);
    idle(); chk("tp5_cnt_1", 32'(obs_cnt), 1);
    idle(); chk("tp5_cnt_0", 32'(obs_cnt), 0);
    step(1, 0, 0, 0, 5, 1, 0, 0, 0);
    chk("tp5_retired", 32'(obs_sel1), 0);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rf_data1   = 16'($urandom);
      rf_data2   = 16'($urandom);
      stage_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 3)), bit'($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 9) == 0));
    end

    // Reset during a load-use stall
    idle(); idle(); idle();
    step(1, 1, 3, 1, 0, 0, 0, 0, 0);
    issue_valid = 1; issue_wr = 0; issue_load = 0; flush = 0;
    src1_addr = 3; src1_used = 1; src2_used = 0;
    #2;
    chk("rs_stall_before", 32'(stall), 1);
    reset = 1'b1;
    #1;
    chk("rs_stall", 32'(stall), 0);
    chk("rs_cnt", 32'(inflight_cnt), 0);
    chk("rs_sel1", 32'(fwd_sel1), 0);
`ifdef HAZARD_PERF_EN
    chk("rs_stall_cycles", stall_cycles, 0);
`endif
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 0, 3, 1, 3, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
